local_branch_predictor: RTL and testbench
=========================================

// Module: local_branch_predictor
// PURPOSE
// - Two-level local branch direction predictor.
// - IF stage: looks up the fetch PC and returns a taken/not-taken guess plus the history snapshot used for it.
// - EX stage: on branch resolution, trains the tables and flags a direction misprediction.
// - The hazard unit consumes the mispredict flag in place of "br_en && op_br".
// PARAMETERS
// - LHT_IDX_BITS  5  local history table index width; 2**5 = 32 entries, indexed by pc[LHT_IDX_BITS+1:2]
// - HIST_BITS     4  per-branch local history length; the PHT has 2**HIST_BITS 2-bit counters
// PORTS
// - clk          in   1          clock, all state updates on rising edge
// - rst          in   1          asynchronous, active-high reset
// - if_valid     in   1          IF stage holds a real fetch
// - if_pc        in   32         fetch PC
// - pred_taken   out  1          predicted direction for if_pc
// - pred_hist    out  HIST_BITS  history snapshot; carried down the pipeline with the instruction
// - ex_update    in   1          branch resolved in EX and EX advances this cycle; at most one pulse per branch
// - ex_pc        in   32         PC of the resolving branch
// - ex_br_en     in   1          actual direction (1 = taken)
// - ex_pred      in   1          pred_taken carried from IF
// - ex_hist      in   HIST_BITS  pred_hist carried from IF
// - mispredict   out  1          ex_update && (ex_br_en != ex_pred)
// BEHAVIOUR
// - Reset: every LHT entry = 0; every PHT counter = WNT (2'b01).
//   Reset is asynchronous and clears the tables immediately, also mid-update; no update occurs on the edge that sees rst=1.
// - Predict (0-cycle, combinational from registered tables):
//     pred_hist  = LHT[if_pc[LHT_IDX_BITS+1:2]]
//     pred_taken = if_valid & PHT[pred_hist][1]
//   With if_valid=0: pred_taken=0; pred_hist still reflects the lookup.
// - Mispredict (combinational): mispredict = ex_update & (ex_br_en ^ ex_pred). It is 0 whenever ex_update=0.
// - Update on the rising edge when ex_update=1:
//     PHT[ex_hist] advances via the counter FSM
//     LHT[ex_pc idx] <= {LHT[ex_pc idx][HIST_BITS-2:0], ex_br_en}
//   The PHT is indexed by the carried snapshot ex_hist, never by the current LHT contents.
// - Counter FSM states:
//   - SNT=00, WNT=01, WT=10, ST=11.
//   - Taken moves one state up, saturating at ST. Not-taken moves one state down, saturating at SNT.
// - Simultaneous predict and update of the same LHT/PHT entry: the prediction returns the pre-update value (no bypass). The new value is visible from the next cycle.
// - ex_update=0: no state change. Stalls are the caller's responsibility: hold ex_update low until EX advances.
// - Aliasing: PCs sharing index bits share history. No tag check.
// CONFIGURATION
// - Macro LBP_PERF_COUNTERS_EN.
//   - Defined: adds outputs perf_branches[31:0] and perf_mispredicts[31:0], both reset to 0.
//     - perf_branches increments on every ex_update.
//     - perf_mispredicts increments when mispredict=1.
//     - Both saturate at 32'hFFFF_FFFF (no wrap).
//   - Undefined: these ports and registers do not exist; all other behaviour is identical.
// STRUCTURE
// - Package lbp_types holds:
//   - typedef enum logic [1:0] lbp_ctr_t {SNT, WNT, WT, ST}
//   - typedef logic [HIST_BITS-1:0] lbp_hist_t
//   - localparam lbp_ctr_t LBP_CTR_RESET = WNT
// - Sub-module lbp_pht:
//   - PHT array with async reset, one read port (IF) and one write port (EX).
//   - Holds the saturating next-state function.
//   - The LHT stays in the top module.
// TESTING
// 1. Reset:
//    - Stimulus: rst pulse, then if_valid=1 at any PC (e.g. 0x60, 0x1FC).
//    - Response: pred_taken=0, pred_hist=0; perf counters 0 (with LBP_PERF_COUNTERS_EN defined).
// 2. Training:
//    - Stimulus: ex_update with ex_pc=0x60, ex_hist=0, ex_br_en=1, repeated twice.
//    - Response:
//      - PHT[0] goes 01 -> 10 -> 11.
//      - LHT[24] goes 0 -> 1 -> 3.
//      - if_pc=0x80 (LHT[0]=0) then predicts taken.
// 3. Saturation:
//    - Stimulus: 5 taken updates with ex_hist=4'h3, then 5 not-taken updates with ex_hist=4'h3.
//    - Response: PHT[3] holds ST after the taken run, then SNT after the not-taken run; never wraps.
// 4. Mispredict:
//    - Stimulus and response:
//      - ex_update=1, ex_pred=0, ex_br_en=1 -> mispredict=1 in the same cycle.
//      - ex_update=0 with the same inputs -> mispredict=0.
// 5. Same-cycle collision:
//    - Stimulus: if_pc=ex_pc=0x60 with ex_update=1 and ex_br_en=1.
//    - Response: pred_hist shows the old LHT value this cycle and the shifted value the next cycle.
// 6. Async reset:
//    - Stimulus: rst asserted mid-cycle while ex_update=1.
//    - Response: tables are cleared before the next edge; that edge applies no update.

Source files
------------

// File: rtl/local_branch_predictor_pkg.sv
// Shared types for the local branch predictor: 2-bit counter states and the history snapshot type.
package lbp_types;

  localparam int unsigned LBP_HIST_BITS    = 4;
  localparam int unsigned LBP_LHT_IDX_BITS = 5;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } lbp_ctr_t;

  typedef logic [LBP_HIST_BITS-1:0] lbp_hist_t;

  localparam lbp_ctr_t LBP_CTR_RESET = WNT;

endpackage

// File: rtl/local_branch_predictor_pht.sv
// Pattern history table: 2**HIST_BITS saturating 2-bit counters.
// One combinational read port for IF and one write port for EX.
module lbp_pht
  import lbp_types::*;
#(
  parameter int unsigned HIST_BITS = LBP_HIST_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HIST_BITS-1:0] rd_idx_i,
  output lbp_ctr_t             rd_ctr_o,
  input  logic                 wr_en_i,
  input  logic [HIST_BITS-1:0] wr_idx_i,
  input  logic                 wr_taken_i
);

  localparam int unsigned ENTRIES = 2 ** HIST_BITS;

  lbp_ctr_t pht_q [ENTRIES];
  lbp_ctr_t ctr_cur;
  lbp_ctr_t ctr_d;

  assign ctr_cur = pht_q[wr_idx_i];

  always_comb begin
    ctr_d = ctr_cur;
    unique case (ctr_cur)
      SNT: ctr_d = wr_taken_i ? WNT : SNT;
      WNT: ctr_d = wr_taken_i ? WT  : SNT;
      WT:  ctr_d = wr_taken_i ? ST  : WNT;
      ST:  ctr_d = wr_taken_i ? ST  : WT;
      default: ctr_d = LBP_CTR_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pht_q[i[HIST_BITS-1:0]] <= LBP_CTR_RESET;
      end
    end else if (wr_en_i) begin
      pht_q[wr_idx_i] <= ctr_d;
    end
  end

  assign rd_ctr_o = pht_q[rd_idx_i];

endmodule

// File: rtl/local_branch_predictor.sv
// Two-level local branch predictor: per-PC history table (LHT) feeding a shared PHT.
// Optional perf counters enabled by defining LBP_PERF_COUNTERS_EN.
module local_branch_predictor
  import lbp_types::*;
#(
  parameter int unsigned LHT_IDX_BITS = LBP_LHT_IDX_BITS,
  parameter int unsigned HIST_BITS    = LBP_HIST_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [31:0]          if_pc,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 ex_update,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_br_en,
  input  logic                 ex_pred,
  input  logic [HIST_BITS-1:0] ex_hist,
  output logic                 mispredict
`ifdef LBP_PERF_COUNTERS_EN
  ,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_mispredicts
`endif
);

  localparam int unsigned LHT_ENTRIES = 2 ** LHT_IDX_BITS;

  logic [HIST_BITS-1:0]    lht_q [LHT_ENTRIES];
  logic [HIST_BITS-1:0]    lht_d;
  logic [LHT_IDX_BITS-1:0] if_idx;
  logic [LHT_IDX_BITS-1:0] ex_idx;
  lbp_ctr_t                pht_rd_ctr;
  logic                    unused_pc_bits;

  assign if_idx = if_pc[LHT_IDX_BITS+1:2];
  assign ex_idx = ex_pc[LHT_IDX_BITS+1:2];

  assign unused_pc_bits = ^{if_pc[31:LHT_IDX_BITS+2], if_pc[1:0],
                            ex_pc[31:LHT_IDX_BITS+2], ex_pc[1:0]};

  // Reads come straight from registered state, so a same-cycle update is not bypassed.
  assign pred_hist  = lht_q[if_idx];
  assign pred_taken = if_valid & pht_rd_ctr[1];
  assign mispredict = ex_update & (ex_br_en ^ ex_pred);

  assign lht_d = {lht_q[ex_idx][HIST_BITS-2:0], ex_br_en};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LHT_ENTRIES; i++) begin
        lht_q[i[LHT_IDX_BITS-1:0]] <= '0;
      end
    end else if (ex_update) begin
      lht_q[ex_idx] <= lht_d;
    end
  end

  // The PHT trains on the snapshot carried from IF, not the current LHT contents.
  lbp_pht #(
    .HIST_BITS (HIST_BITS)
  ) u_pht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (pred_hist),
    .rd_ctr_o   (pht_rd_ctr),
    .wr_en_i    (ex_update),
    .wr_idx_i   (ex_hist),
    .wr_taken_i (ex_br_en)
  );

`ifdef LBP_PERF_COUNTERS_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  always_comb begin
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (ex_update && (perf_branches_q != '1)) begin
      perf_branches_d = perf_branches_q + 32'd1;
    end
    if (mispredict && (perf_mispredicts_q != '1)) begin
      perf_mispredicts_d = perf_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_local_branch_predictor.sv
// Directed self-checking bench for local_branch_predictor; expected values are hand-derived.
module tb_local_branch_predictor;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [3:0]  pred_hist;
  logic        ex_update;
  logic [31:0] ex_pc;
  logic        ex_br_en;
  logic        ex_pred;
  logic [3:0]  ex_hist;
  logic        mispredict;
`ifdef LBP_PERF_COUNTERS_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_br   = 0;
  int unsigned exp_mp   = 0;

  local_branch_predictor #(
    .LHT_IDX_BITS (5),
    .HIST_BITS    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .pred_taken (pred_taken),
    .pred_hist  (pred_hist),
    .ex_update  (ex_update),
    .ex_pc      (ex_pc),
    .ex_br_en   (ex_br_en),
    .ex_pred    (ex_pred),
    .ex_hist    (ex_hist),
    .mispredict (mispredict)
`ifdef LBP_PERF_COUNTERS_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic v);
    if_pc    = pc;
    if_valid = v;
    #1;
  endtask

  // Assumes the caller is just after a rising edge; returns 1 time unit after the next one.
  task automatic upd(input logic [31:0] pc, input logic br, input logic pred, input logic [3:0] hist);
    ex_pc     = pc;
    ex_br_en  = br;
    ex_pred   = pred;
    ex_hist   = hist;
    ex_update = 1'b1;
    @(posedge clk);
    #1;
    ex_update = 1'b0;
    exp_br++;
    if (br != pred) exp_mp++;
  endtask

  task automatic check_perf(input string tag);
`ifdef LBP_PERF_COUNTERS_EN
    check({tag, "_branches"}, perf_branches, exp_br);
    check({tag, "_mispredicts"}, perf_mispredicts, exp_mp);
`else
    if (tag.len() == 0) $display("empty perf tag");
`endif
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_pc = '0;
    ex_update = 1'b0; ex_pc = '0; ex_br_en = 1'b0; ex_pred = 1'b0; ex_hist = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    look(32'h60, 1'b1);
    check("rst_taken_60", {31'b0, pred_taken}, 32'd0);
    check("rst_hist_60", {28'b0, pred_hist}, 32'd0);
    look(32'h1FC, 1'b1);
    check("rst_taken_1fc", {31'b0, pred_taken}, 32'd0);
    check("rst_hist_1fc", {28'b0, pred_hist}, 32'd0);
    check_perf("rst");

    // Training: PHT[0] 01->10->11, LHT[24] 0->1->3
    upd(32'h60, 1'b1, 1'b0, 4'h0);
    look(32'h60, 1'b1);
    check("train1_hist_60", {28'b0, pred_hist}, 32'd1);
    look(32'h80, 1'b1);
    check("train1_taken_80", {31'b0, pred_taken}, 32'd1);
    check("train1_hist_80", {28'b0, pred_hist}, 32'd0);
    upd(32'h60, 1'b1, 1'b1, 4'h0);
    look(32'h60, 1'b1);
    check("train2_hist_60", {28'b0, pred_hist}, 32'd3);
    look(32'h80, 1'b1);
    check("train2_taken_80", {31'b0, pred_taken}, 32'd1);
    look(32'h80, 1'b0);
    check("novalid_taken_80", {31'b0, pred_taken}, 32'd0);
    check("novalid_hist_80", {28'b0, pred_hist}, 32'd0);
    look(32'h60, 1'b0);
    check("novalid_hist_60", {28'b0, pred_hist}, 32'd3);

    // Saturation on PHT[3], observed through LHT[24]=3; trained from PC 0x04 (LHT[1])
    for (int i = 0; i < 5; i++) upd(32'h04, 1'b1, 1'b1, 4'h3);
    look(32'h60, 1'b1);
    check("sat_up_taken", {31'b0, pred_taken}, 32'd1);
    look(32'h04, 1'b1);
    check("sat_up_hist_04", {28'b0, pred_hist}, 32'hF);
    upd(32'h04, 1'b0, 1'b1, 4'h3);
    look(32'h60, 1'b1);
    check("sat_st_then_nt", {31'b0, pred_taken}, 32'd1);
    for (int i = 0; i < 4; i++) upd(32'h04, 1'b0, 1'b0, 4'h3);
    look(32'h60, 1'b1);
    check("sat_down_taken", {31'b0, pred_taken}, 32'd0);
    upd(32'h04, 1'b1, 1'b0, 4'h3);
    look(32'h60, 1'b1);
    check("sat_snt_then_t", {31'b0, pred_taken}, 32'd0);
    upd(32'h04, 1'b1, 1'b0, 4'h3);
    look(32'h60, 1'b1);
    check("sat_wt_taken", {31'b0, pred_taken}, 32'd1);
    look(32'h04, 1'b1);
    check("sat_hist_04", {28'b0, pred_hist}, 32'h3);

    // Mispredict is combinational and gated by ex_update
    ex_pc = 32'h08; ex_hist = 4'h0;
    ex_pred = 1'b0; ex_br_en = 1'b1; ex_update = 1'b1; #1;
    check("mp_p0_t1", {31'b0, mispredict}, 32'd1);
    ex_pred = 1'b1; #1;
    check("mp_p1_t1", {31'b0, mispredict}, 32'd0);
    ex_br_en = 1'b0; #1;
    check("mp_p1_t0", {31'b0, mispredict}, 32'd1);
    ex_update = 1'b0; #1;
    check("mp_noupd_p1_t0", {31'b0, mispredict}, 32'd0);
    ex_pred = 1'b0; ex_br_en = 1'b1; #1;
    check("mp_noupd_p0_t1", {31'b0, mispredict}, 32'd0);

    // Same-cycle collision on LHT[24]: old value now, shifted value next cycle
    @(posedge clk); #1;
    if_pc = 32'h60; if_valid = 1'b1;
    ex_pc = 32'h60; ex_br_en = 1'b1; ex_pred = 1'b1; ex_hist = 4'h0; ex_update = 1'b1;
    #1;
    check("coll_hist_old", {28'b0, pred_hist}, 32'd3);
    @(posedge clk); #1;
    ex_update = 1'b0;
    exp_br++;
    check("coll_hist_new", {28'b0, pred_hist}, 32'd7);
    check_perf("pre_async");

    // Async reset mid-cycle while an update is pending
    ex_pc = 32'h60; ex_br_en = 1'b1; ex_pred = 1'b0; ex_hist = 4'h0; ex_update = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_br = 0; exp_mp = 0;
    look(32'h60, 1'b1);
    check("arst_hist_60", {28'b0, pred_hist}, 32'd0);
    look(32'h80, 1'b1);
    check("arst_taken_80", {31'b0, pred_taken}, 32'd0);
    check_perf("arst");
    @(posedge clk); #1;
    look(32'h60, 1'b1);
    check("arst_edge_hist_60", {28'b0, pred_hist}, 32'd0);
    look(32'h80, 1'b1);
    check("arst_edge_taken_80", {31'b0, pred_taken}, 32'd0);
    rst = 1'b0; ex_update = 1'b0;
    @(posedge clk); #1;
    look(32'h60, 1'b1);
    check("post_rst_hist_60", {28'b0, pred_hist}, 32'd0);
    check_perf("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
